// File: rtl/axi4lite_master_bfm.sv
// AXI4-Lite master driven by a simple command/response stream.
// One command is in flight at a time. Each command returns exactly one
// response record. A per-transaction timeout aborts the command if the
// slave hangs.
module axi4lite_master_bfm #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,   // 32 or 64
  parameter int TIMEOUT_CYCLES = 256   // 0 disables the timeout
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  // command stream
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  // response stream
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  // write address channel
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [2:0]              AWPROT,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  // write data channel
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  // write response channel
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  // read address channel
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [2:0]              ARPROT,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  // read data channel
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RVALID,
  output logic                    RREADY
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WADDR_DATA,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA,
    ST_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;
  logic                    timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    in_flight;
  logic                    done;

  // Next-state and next-output logic; expiry overrides everything except a
  // completion handshake in the same cycle.
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    write_d   = write_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    in_flight = 1'b0;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          write_d   = cmd_write;
          timeout_d = 1'b0;
          cnt_d     = '0;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RADDR;
          end
        end
      end
      ST_WADDR_DATA: begin
        in_flight = 1'b1;
        if (awvalid_q && AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
        // each channel is done once its VALID is gone or is handshaking now
        if ((!awvalid_q || AWREADY) && (!wvalid_q || WREADY)) begin
          bready_d = 1'b1;
          state_d  = ST_WRESP;
        end
      end
      ST_WRESP: begin
        in_flight = 1'b1;
        if (BVALID && bready_q) begin
          done     = 1'b1;
          resp_d   = BRESP;
          rdata_d  = '0;
          bready_d = 1'b0;
          state_d  = ST_RESP;
        end
      end
      ST_RADDR: begin
        in_flight = 1'b1;
        if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RDATA;
        end
      end
      ST_RDATA: begin
        in_flight = 1'b1;
        if (RVALID && rready_q) begin
          done     = 1'b1;
          rdata_d  = RDATA;
          resp_d   = RRESP;
          rready_d = 1'b0;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (in_flight) cnt_d = cnt_q + CNT_WIDTH'(1);

    if ((TIMEOUT_CYCLES != 0) && in_flight && !done && (cnt_q == CNT_LAST)) begin
      state_d   = ST_RESP;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      resp_d    = 2'b10;
      rdata_d   = '0;
      timeout_d = 1'b1;
    end
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      write_q   <= write_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_write   = write_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign rsp_timeout = timeout_q;
  assign AWADDR      = addr_q;
  assign AWPROT      = 3'b000;
  assign AWVALID     = awvalid_q;
  assign WDATA       = wdata_q;
  assign WSTRB       = wstrb_q;
  assign WVALID      = wvalid_q;
  assign BREADY      = bready_q;
  assign ARADDR      = addr_q;
  assign ARPROT      = 3'b000;
  assign ARVALID     = arvalid_q;
  assign RREADY      = rready_q;

endmodule

// File: doc/axi4lite_master_bfm.md
Name: axi4lite_master_bfm

Overview:
- Synthesizable AXI4-Lite master that sits directly downstream of the testbench stimulus generator.
- Consumes one read or write command at a time. The command corresponds to a STIMULUS_READY_READ or STIMULUS_READY_WRITE message.
- Drives the AXI4-Lite channels of the DUT slave and returns one response record per command to the checker side.
- Includes a per-transaction timeout so a hung slave cannot stall the bench.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr, AWADDR, ARADDR.
- DATA_WIDTH, 32, data width; must be 32 or 64. Strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, cycles allowed from the first bus VALID to completion. 0 disables the timeout.

Ports:
- ACLK  in  1  single clock, all logic on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  master can accept a command.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- cmd_wstrb  in  DATA_WIDTH/8  byte strobes; ignored for reads.
- rsp_valid  out  1  response record available.
- rsp_ready  in  1  consumer takes the response.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout.
- rsp_timeout  out  1  transaction aborted by timeout.
- AWADDR/AWPROT/AWVALID  out  ADDR_WIDTH/3/1; AWREADY in 1.
- WDATA/WSTRB/WVALID  out  DATA_WIDTH/DATA_WIDTH/8/1; WREADY in 1.
- BRESP in 2, BVALID in 1, BREADY out 1.
- ARADDR/ARPROT/ARVALID  out  ADDR_WIDTH/3/1; ARREADY in 1.
- RDATA in DATA_WIDTH, RRESP in 2, RVALID in 1, RREADY out 1.

Behaviour:
- Outputs are registered. A/W/B/R follow AXI4-Lite handshake rules: a transfer occurs on a cycle where VALID and READY are both high.
- Reset (ARESET=1 at a rising edge):
  - Next-cycle values: state=IDLE, cmd_ready=1; all of *VALID, BREADY, RREADY, rsp_valid, rsp_timeout = 0.
  - rsp_rdata, rsp_resp, AxADDR, WDATA, WSTRB = 0.
  - Reset mid-transaction abandons the transaction; no response is produced.
- AWPROT and ARPROT are constant 3'b000.
- States: IDLE, WADDR_DATA, WRESP, RADDR, RDATA, RESP.
- IDLE:
  - cmd_ready=1; it is 0 in every other state.
  - On cmd_valid&cmd_ready, latch all cmd fields and clear the timeout counter.
  - cmd_write=1 -> WADDR_DATA, with AWVALID=WVALID=1 from the next cycle.
  - cmd_write=0 -> RADDR, with ARVALID=1.
- WADDR_DATA:
  - AW and W are independent; each VALID drops the cycle after its own handshake.
  - AW and W may complete in either order or in the same cycle.
  - When both are done -> WRESP with BREADY=1.
  - AxADDR/WDATA/WSTRB stay stable while the corresponding VALID is high.
- WRESP: on BVALID&BREADY, capture BRESP, set rsp_rdata=0, drop BREADY -> RESP.
- RADDR: on ARVALID&ARREADY, drop ARVALID, raise RREADY -> RDATA.
- RDATA: on RVALID&RREADY, capture RDATA and RRESP, drop RREADY -> RESP.
- RESP:
  - rsp_valid=1 with stable fields until rsp_valid&rsp_ready, then -> IDLE.
  - A new command is accepted no earlier than the cycle after the response handshake.
- BREADY is high only in WRESP; RREADY is high only in RDATA. Slave B/R activity in other states is ignored.
- Minimum latency, zero-wait slave: command accepted at cycle 0 -> AWVALID/ARVALID at cycle 1 -> B/R handshake at cycle 2 -> rsp_valid at cycle 3.
- Timeout:
  - Counter increments every cycle in WADDR_DATA, WRESP, RADDR and RDATA.
  - At count==TIMEOUT_CYCLES-1 with no completion, the next state is RESP: all VALID/READY deasserted, rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
  - A completion handshake in the same cycle as expiry wins; the response is normal and rsp_timeout=0.
  - With TIMEOUT_CYCLES=0 the master never times out.
- rsp_timeout clears when the next command is accepted.

Test Plan:
- Zero-wait slave, write addr 0x10, data 0xDEADBEEF, strb 4'hF -> AWVALID/WVALID at cycle 1; rsp_valid at cycle 3 with rsp_write=1, rsp_resp=0, rsp_rdata=0.
- Read 0x10, slave RDATA=0xDEADBEEF after 4 wait cycles on ARREADY -> ARADDR stable throughout; rsp_rdata=0xDEADBEEF, rsp_resp=0.
- Write with WREADY 3 cycles before AWREADY, then the reverse, then both in the same cycle -> exactly one AW and one W handshake each; BREADY rises only after both complete.
- Slave never asserts BVALID, TIMEOUT_CYCLES=16 -> all VALID/READY low after 16 cycles; rsp_resp=2'b10, rsp_timeout=1. The next command proceeds normally.
- rsp_ready held low for 5 cycles; cmd_valid held high -> rsp fields stable and cmd_ready=0 until the response handshake; next command accepted the cycle after.
- ARESET pulsed while in RDATA -> next cycle state is IDLE, RREADY=0, rsp_valid=0, cmd_ready=1.
